// File: rtl/sa_scan_pkg.sv
// Shared types and constants for the SA scan chain controller.
// Optional MISR is enabled with SA_SCAN_CHAIN_CTRL_MISR_EN.
package sa_scan_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } scan_state_e;

  localparam int MISR_W = 32;
  localparam logic [MISR_W-1:0] MISR_POLY_DEF = 32'h04C11DB7;

endpackage

// File: rtl/sa_scan_chain_ctrl_misr.sv
// Serial-in Galois MISR with synchronous clear (clear beats update).
// Instantiated by the controller only under SA_SCAN_CHAIN_CTRL_MISR_EN.
module sa_scan_misr
  import sa_scan_pkg::*;
#(
  parameter logic [MISR_W-1:0] POLY = MISR_POLY_DEF
) (
  input  logic              CP,
  input  logic              CDN,
  input  logic              clr,
  input  logic              en,
  input  logic              din,
  output logic [MISR_W-1:0] sig
);

  logic fb;
  assign fb = sig[MISR_W-1] ^ din;

  always_ff @(posedge CP or negedge CDN) begin
    if (!CDN) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[MISR_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end

endmodule

// File: rtl/sa_scan_chain_ctrl.sv
// Scan chain load/unload controller with optional capture cycle.
// Define SA_SCAN_CHAIN_CTRL_MISR_EN to add the scan-out MISR.
module sa_scan_chain_ctrl
  import sa_scan_pkg::*;
#(
  parameter int CHAIN_LEN = 16,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
`ifdef SA_SCAN_CHAIN_CTRL_MISR_EN
  ,
  parameter logic [MISR_W-1:0] MISR_POLY = MISR_POLY_DEF
`endif
) (
  input  logic                 CP,
  input  logic                 CDN,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [CHAIN_LEN-1:0] req_pattern,
  input  logic                 req_capture,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CHAIN_LEN-1:0] rsp_data,
  output logic                 scan_se,
  output logic                 scan_si,
  input  logic                 scan_so,
  output logic                 busy
`ifdef SA_SCAN_CHAIN_CTRL_MISR_EN
  ,
  input  logic                 misr_clr,
  output logic [MISR_W-1:0]    misr_sig
`endif
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

  scan_state_e          state;
  logic [CNT_W-1:0]     cnt;
  logic [CHAIN_LEN-1:0] pat_q;
  logic [CHAIN_LEN-1:0] rsp_q;
  logic                 cap_q;

  assign rsp_data = rsp_q;

  // pat_q/rsp_q shift so bit cnt is always at the serial end
  always_ff @(posedge CP or negedge CDN) begin
    if (!CDN) begin
      state     <= IDLE;
      cnt       <= '0;
      pat_q     <= '0;
      rsp_q     <= '0;
      cap_q     <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      scan_se   <= 1'b0;
      scan_si   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            pat_q     <= req_pattern;
            cap_q     <= req_capture;
            cnt       <= '0;
            scan_si   <= req_pattern[0];
            scan_se   <= 1'b1;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          rsp_q <= {scan_so, rsp_q[CHAIN_LEN-1:1]};
          pat_q <= pat_q >> 1;
          if (cnt == LAST) begin
            cnt     <= '0;
            scan_se <= 1'b0;
            scan_si <= 1'b0;
            if (cap_q) begin
              state <= CAPTURE;
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end
          end else begin
            cnt     <= cnt + 1'b1;
            scan_si <= pat_q[1];
          end
        end
        CAPTURE: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SA_SCAN_CHAIN_CTRL_MISR_EN
  sa_scan_misr #(
    .POLY(MISR_POLY)
  ) u_misr (
    .CP  (CP),
    .CDN (CDN),
    .clr (misr_clr),
    .en  (state == SHIFT),
    .din (scan_so),
    .sig (misr_sig)
  );
`endif

endmodule

// File: tb/tb_sa_scan_chain_ctrl.sv
// Directed bench for sa_scan_chain_ctrl with an 8-cell scan chain model.
// Define SA_SCAN_CHAIN_CTRL_MISR_EN to also exercise the MISR.
module tb_sa_scan_chain_ctrl;

  logic       CP = 1'b0;
  logic       CDN = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_pattern = '0;
  logic       req_capture = 1'b0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_data;
  logic       scan_se;
  logic       scan_si;
  logic       scan_so;
  logic       busy;
`ifdef SA_SCAN_CHAIN_CTRL_MISR_EN
  logic        misr_clr = 1'b0;
  logic [31:0] misr_sig;
`endif

  int n_chk = 0;
  int n_err = 0;

  // Chain cells: shift when SE, else load D (hold Q, or tied to 3C)
  logic [7:0] chain = 8'h6E;
  logic       dmode = 1'b0;
  assign scan_so = chain[7];

  always @(posedge CP) begin
    if (scan_se) chain <= {chain[6:0], scan_si};
    else if (dmode) chain <= 8'h3C;
  end

  always #5 CP = ~CP;

  sa_scan_chain_ctrl #(
    .CHAIN_LEN(8)
  ) dut (
    .CP          (CP),
    .CDN         (CDN),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_pattern (req_pattern),
    .req_capture (req_capture),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .scan_se     (scan_se),
    .scan_si     (scan_si),
    .scan_so     (scan_so),
    .busy        (busy)
`ifdef SA_SCAN_CHAIN_CTRL_MISR_EN
    ,
    .misr_clr    (misr_clr),
    .misr_sig    (misr_sig)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request at a negedge; return at the negedge after accept
  task automatic send(input logic [7:0] pat, input logic cap);
    int t;
    t = 0;
    req_pattern = pat;
    req_capture = cap;
    req_valid = 1'b1;
    while (!req_ready && t < 50) begin
      @(negedge CP);
      t++;
    end
    chk("accept_timeout", 32'(t < 50), 32'd1);
    @(negedge CP);
    req_valid = 1'b0;
  endtask

  // Latency counts edges from the accept edge to the rsp_valid edge
  task automatic collect(input logic [7:0] pat, input logic [7:0] exp,
                         input logic cap, input int hold);
    int lat, se_n, gap, t;
    logic [7:0] si_seq;
    lat = 1; se_n = 0; gap = 0; t = 0; si_seq = '0;
    rsp_ready = (hold == 0);
    while (!rsp_valid && t < 40) begin
      if (scan_se) begin
        if (se_n < 8) si_seq[se_n] = scan_si;
        se_n++;
      end else if (se_n > 0) begin
        gap++;
      end
      lat++;
      t++;
      @(negedge CP);
    end
    chk("rsp_timeout", 32'(rsp_valid), 32'd1);
    chk("latency", 32'(lat), cap ? 32'd10 : 32'd9);
    chk("se_cycles", 32'(se_n), 32'd8);
    chk("capture_gap", 32'(gap), 32'(cap));
    chk("si_order", 32'(si_seq), 32'(pat));
    chk("rsp_data", 32'(rsp_data), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      @(negedge CP);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data", 32'(rsp_data), 32'(exp));
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge CP);
    chk("rsp_drop", 32'(rsp_valid), 32'd0);
  endtask

`ifdef SA_SCAN_CHAIN_CTRL_MISR_EN
  function automatic logic [31:0] misr_ref(input logic [7:0] bits);
    logic [31:0] s;
    logic fb;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      fb = s[31] ^ bits[i];
      s = {s[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
    end
    return s;
  endfunction
`endif

  initial begin
    int rv_seen;
    repeat (3) @(negedge CP);
    chk("rst_se", 32'(scan_se), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    CDN = 1'b1;
    @(negedge CP);
    chk("idle_ready", 32'(req_ready), 32'd1);
    chk("idle_se", 32'(scan_se), 32'd0);
    chk("idle_valid", 32'(rsp_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_data", 32'(rsp_data), 32'd0);
    chk("idle_si", 32'(scan_si), 32'd0);

    // Initial chain 6E unloads bit-reversed
    send(8'hA5, 1'b0);
    chk("shift_busy", 32'(busy), 32'd1);
    collect(8'hA5, 8'h76, 1'b0, 0);
    send(8'hA5, 1'b0);
    collect(8'hA5, 8'hA5, 1'b0, 0);

    // Capture with D tied to 3C
    dmode = 1'b1;
    send(8'hFF, 1'b1);
    collect(8'hFF, 8'h3C, 1'b1, 0);
    send(8'h00, 1'b0);
    collect(8'h00, 8'h3C, 1'b0, 0);
    dmode = 1'b0;

    // Backpressure, request held while busy
    send(8'h5A, 1'b0);
    req_pattern = 8'hC3;
    req_valid = 1'b1;
    collect(8'h5A, 8'h3C, 1'b0, 5);
    chk("gap_busy", 32'(busy), 32'd0);
    chk("gap_ready", 32'(req_ready), 32'd1);
    @(negedge CP);
    chk("next_accept", 32'(busy), 32'd1);
    req_valid = 1'b0;
    collect(8'hC3, 8'h5A, 1'b0, 0);

    // Reset after three shift edges of 0F into chain C3
    send(8'h0F, 1'b0);
    repeat (3) @(posedge CP);
    #2 CDN = 1'b0;
    #1;
    chk("mid_rst_se", 32'(scan_se), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    rv_seen = 0;
    repeat (3) begin
      @(negedge CP);
      if (rsp_valid) rv_seen++;
    end
    CDN = 1'b1;
    repeat (12) begin
      @(negedge CP);
      if (rsp_valid) rv_seen++;
    end
    chk("mid_rst_no_rsp", 32'(rv_seen), 32'd0);
    send(8'h96, 1'b0);
    collect(8'h96, 8'hF8, 1'b0, 0);
    send(8'h00, 1'b0);
    collect(8'h00, 8'h96, 1'b0, 0);

`ifdef SA_SCAN_CHAIN_CTRL_MISR_EN
    send(8'h01, 1'b0);
    collect(8'h01, 8'h00, 1'b0, 0);
    misr_clr = 1'b1;
    @(negedge CP);
    misr_clr = 1'b0;
    chk("misr_clr", misr_sig, 32'h0);
    send(8'h00, 1'b0);
    collect(8'h00, 8'h01, 1'b0, 0);
    chk("misr_sig", misr_sig, misr_ref(8'h01));
    misr_clr = 1'b1;
    send(8'h00, 1'b0);
    collect(8'h00, 8'h00, 1'b0, 0);
    chk("misr_clr_win", misr_sig, 32'h0);
    misr_clr = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sa_scan_chain_ctrl.md
Name: sa_scan_chain_ctrl

Overview:
- Drives one scan chain of SA scan flops: generates scan enable and scan-in, and collects scan-out.
- Accepts CHAIN_LEN-bit load patterns over a valid/ready request port.
- Shifts each pattern in while shifting the previous chain contents out, then optionally issues one functional capture cycle.
- Returns the unloaded bits on a valid/ready response port.
- Sits directly upstream of the chain: its scan_se/scan_si feed the cells' SE/SI, and the last cell's Q returns as scan_so.

Parameters:
- CHAIN_LEN, 16, number of scan flops in the chain (2..1024).
- CNT_W, $clog2(CHAIN_LEN+1), shift counter width (derived; do not override).
- MISR_POLY, 32'h04C11DB7, feedback polynomial for the optional signature register.

Ports:
- CP  input  1  clock; rising edge; shared with the chain cells.
- CDN  input  1  asynchronous active-low reset.
- req_valid  input  1  pattern request valid.
- req_ready  output  1  controller can accept a pattern.
- req_pattern  input  CHAIN_LEN  bit i is driven on scan_si in shift cycle i.
- req_capture  input  1  1 = issue one capture cycle after the shift.
- rsp_valid  output  1  unloaded data valid.
- rsp_ready  input  1  consumer accepts the response.
- rsp_data  output  CHAIN_LEN  bit i is scan_so sampled in shift cycle i.
- scan_se  output  1  to the SE pins of the chain cells.
- scan_si  output  1  to the SI pin of the first cell.
- scan_so  input  1  Q of the last cell.
- busy  output  1  state != IDLE.

Behaviour:
- Clocking: single clock CP. Reset is asynchronous and active-low on CDN; all state clears immediately on CDN=0.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_data=0, scan_se=0, scan_si=0, busy=0, counter=0.
- States: IDLE, SHIFT, CAPTURE, RESP.
- IDLE:
  - req_ready=1.
  - On the edge where req_valid&req_ready: latch req_pattern into pat_q and req_capture into cap_q, clear counter, go to SHIFT.
- SHIFT:
  - Lasts exactly CHAIN_LEN cycles; scan_se=1.
  - scan_si = pat_q[counter], driven from a flop so it is stable for the whole cycle.
  - At each CP edge, scan_so is sampled into rsp_q[counter] and the counter increments. The chain shifts on the same edge.
  - At counter==CHAIN_LEN-1 go to CAPTURE if cap_q, else RESP.
- CAPTURE:
  - Exactly one cycle; scan_se=0, so the chain loads functional D. Then go to RESP.
- RESP:
  - rsp_valid=1 and rsp_data=rsp_q, stable until handshake; scan_se=0.
  - On rsp_valid&rsp_ready go to IDLE.
- scan_se is 1 only in SHIFT and is glitch-free (registered output).
- Pattern-to-response latency: CHAIN_LEN+1 cycles without capture, CHAIN_LEN+2 with capture, from the accept edge to rsp_valid high.
- Unload semantics: rsp_data is the chain content before this load, i.e. the previous capture result. The first response after reset reflects the chain's reset/power-up state.
- Boundary conditions:
  - req_ready=0 in SHIFT/CAPTURE/RESP; there is no request queueing. req_valid held during busy is ignored until IDLE.
  - rsp_ready=1 already on the first RESP cycle: single-cycle RESP.
  - Back-to-back requests: the earliest next accept is the cycle after the RESP handshake (one IDLE cycle minimum).
  - CDN asserted mid-SHIFT: scan_se drops to 0 immediately. The partial response is discarded and no rsp_valid is produced.
  - Counter never exceeds CHAIN_LEN-1; no wrap is visible outside.

Optional Feature:
- Macro SA_SCAN_CHAIN_CTRL_MISR_EN.
- When defined:
  - Adds output misr_sig[31:0] and input misr_clr.
  - A 32-bit MISR (Galois form, MISR_POLY) absorbs each scan_so bit on every SHIFT edge, in the same cycles rsp_q samples.
  - misr_clr=1 synchronously zeroes it; CDN resets it to 0.
  - misr_clr and a SHIFT update in the same cycle: clear wins.
- When undefined: the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package sa_scan_pkg:
  - state enum typedef (IDLE/SHIFT/CAPTURE/RESP, 2-bit encoding 0..3).
  - MISR width constant 32 and default polynomial.
- Optional sub-module sa_scan_misr (serial-in 32-bit MISR with clear), instantiated only under the macro.

Test Plan:
- Reset and idle: CHAIN_LEN=8, chain of 8 scan cells modelled in the bench, hold CDN=0 then release -> req_ready=1, scan_se=0, rsp_valid=0.
- Shift only: pattern 8'hA5, capture=0, twice -> first rsp_data = initial chain contents; second rsp_data = 8'hA5 in the defined bit order; scan_se high exactly 8 cycles each; latency 9 cycles.
- Capture: chain D inputs tied to 8'h3C, pattern 8'hFF with capture=1, then any pattern -> scan_se low for exactly 1 cycle between the shift and RESP; the second response = 8'h3C.
- Backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_data stable; req_valid ignored; the next accept occurs one cycle after the handshake.
- Reset mid-shift: CDN low at shift cycle 3 -> scan_se=0 at once, no rsp_valid; a clean restart after release.
- MISR (macro on): misr_clr, then shift out known stream 8'h01 -> misr_sig equals the reference-model value; misr_clr coincident with a shift edge -> misr_sig=0.
